// File: rtl/multicycle_control_if.sv
// Handshake/strobe bundle between the multicycle_control FSM and the
// Core101 datapath plus instruction/data memory interfaces.
// master: the control FSM. slave: the datapath/memory side.
interface multicycle_control_if #(
  parameter int PC_SEL_W = 2,
  parameter int OPCODE_W = 7
);
  // Datapath / memory -> control
  logic [OPCODE_W-1:0] multicycle_control_opcode_in;
  logic                multicycle_control_branch_taken_in;
  logic                multicycle_control_stall_in;
  logic                multicycle_control_imem_ready_in;
  logic                multicycle_control_dmem_ready_in;

  // Control -> datapath / memory
  logic                multicycle_control_imem_req_out;
  logic                multicycle_control_dmem_req_out;
  logic                multicycle_control_dmem_we_out;
  logic                multicycle_control_pc_set_val_out;
  logic                multicycle_control_ir_set_val_out;
  logic [PC_SEL_W-1:0] multicycle_control_pc_mux_sel_out;
  logic                multicycle_control_rf_we_out;
  logic [2:0]          multicycle_control_state_out;
  logic                multicycle_control_fault_out;

  modport master (
    input  multicycle_control_opcode_in,
    input  multicycle_control_branch_taken_in,
    input  multicycle_control_stall_in,
    input  multicycle_control_imem_ready_in,
    input  multicycle_control_dmem_ready_in,
    output multicycle_control_imem_req_out,
    output multicycle_control_dmem_req_out,
    output multicycle_control_dmem_we_out,
    output multicycle_control_pc_set_val_out,
    output multicycle_control_ir_set_val_out,
    output multicycle_control_pc_mux_sel_out,
    output multicycle_control_rf_we_out,
    output multicycle_control_state_out,
    output multicycle_control_fault_out
  );

  modport slave (
    output multicycle_control_opcode_in,
    output multicycle_control_branch_taken_in,
    output multicycle_control_stall_in,
    output multicycle_control_imem_ready_in,
    output multicycle_control_dmem_ready_in,
    input  multicycle_control_imem_req_out,
    input  multicycle_control_dmem_req_out,
    input  multicycle_control_dmem_we_out,
    input  multicycle_control_pc_set_val_out,
    input  multicycle_control_ir_set_val_out,
    input  multicycle_control_pc_mux_sel_out,
    input  multicycle_control_rf_we_out,
    input  multicycle_control_state_out,
    input  multicycle_control_fault_out
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: IF/ID/EX/MEM/WB control FSM for the Core101 RV32I
// multi-cycle datapath. Skips states by the opcode latched in ID, waits on
// imem/dmem ready, honours a global stall and drives PC/IR/RF/dmem strobes.
// Optional handshake timeout with a sticky FAULT state is enabled by
// defining MULTICYCLE_CONTROL_TIMEOUT_EN.
module multicycle_control #(
  parameter int PC_SEL_W    = 2,
  parameter int OPCODE_W    = 7,
  parameter int MEM_TIMEOUT = 15
) (
  input logic                 multicycle_control_clock_in,
  input logic                 multicycle_control_reset_in,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    S_IF    = 3'b000,
    S_ID    = 3'b001,
    S_EX    = 3'b011,
    S_MEM   = 3'b010,
    S_WB    = 3'b110
`ifdef MULTICYCLE_CONTROL_TIMEOUT_EN
    , S_FAULT = 3'b111
`endif
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_BRANCH = OPCODE_W'(7'b1100011);
  localparam logic [OPCODE_W-1:0] OP_JAL    = OPCODE_W'(7'b1101111);
  localparam logic [OPCODE_W-1:0] OP_JALR   = OPCODE_W'(7'b1100111);
  localparam logic [OPCODE_W-1:0] OP_IMM    = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_OP     = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_LUI    = OPCODE_W'(7'b0110111);
  localparam logic [OPCODE_W-1:0] OP_AUIPC  = OPCODE_W'(7'b0010111);

  localparam logic [PC_SEL_W-1:0] SEL_PC4  = PC_SEL_W'(0);
  localparam logic [PC_SEL_W-1:0] SEL_BR   = PC_SEL_W'(1);
  localparam logic [PC_SEL_W-1:0] SEL_JAL  = PC_SEL_W'(2);
  localparam logic [PC_SEL_W-1:0] SEL_JALR = PC_SEL_W'(3);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q;
  logic                opcode_en;

  logic                imem_req, dmem_req, dmem_we;
  logic                pc_set, ir_set, rf_we, fault;
  logic [PC_SEL_W-1:0] pc_sel;

  // NOTE: strobes are qualified by reset as well as stall, so an async
  // reset mid-instruction cannot leak a load/write pulse while rst is low.
  logic run;
  assign run = multicycle_control_reset_in && !bus.multicycle_control_stall_in;

  // Decode of the latched opcode; EX/MEM/WB never look at the live IR.
  logic is_load, is_store, is_branch, writes_rf;
  assign is_load   = (opcode_q == OP_LOAD);
  assign is_store  = (opcode_q == OP_STORE);
  assign is_branch = (opcode_q == OP_BRANCH);
  assign writes_rf = is_load || (opcode_q == OP_IMM) || (opcode_q == OP_OP) ||
                     (opcode_q == OP_LUI) || (opcode_q == OP_AUIPC) ||
                     (opcode_q == OP_JAL) || (opcode_q == OP_JALR);

  // A handshake state with its ready still low this cycle.
  logic waiting;
  assign waiting = ((state_q == S_IF)  && !bus.multicycle_control_imem_ready_in) ||
                   ((state_q == S_MEM) && !bus.multicycle_control_dmem_ready_in);

`ifdef MULTICYCLE_CONTROL_TIMEOUT_EN
  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             tmo_hit;

  // Last unready, unstalled cycle before the budget is exhausted.
  assign tmo_hit = run && waiting && (tmo_cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  // Wait-cycle counter: counts unstalled unready cycles, clears on any move.
  always_ff @(posedge multicycle_control_clock_in or negedge multicycle_control_reset_in) begin
    if (!multicycle_control_reset_in) begin
      tmo_cnt_q <= '0;
    end else if (state_d != state_q) begin
      tmo_cnt_q <= '0;
    end else if (run && waiting) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end
`else
  logic tmo_hit;
  assign tmo_hit = 1'b0;
  localparam int unused_mem_timeout = MEM_TIMEOUT;
  logic unused_waiting;
  assign unused_waiting = waiting;
`endif

  // State and latched-opcode registers.
  always_ff @(posedge multicycle_control_clock_in or negedge multicycle_control_reset_in) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!multicycle_control_reset_in) begin
      state_q  <= S_IF;
      opcode_q <= '0;
    end else begin
      state_q <= state_d;
      if (opcode_en) begin
        opcode_q <= bus.multicycle_control_opcode_in;
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d   = state_q;
    opcode_en = 1'b0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_set    = 1'b0;
    ir_set    = 1'b0;
    pc_sel    = SEL_PC4;
    rf_we     = 1'b0;
    fault     = 1'b0;

    case (state_q)
      S_IF: begin
        imem_req = 1'b1;
        if (run && bus.multicycle_control_imem_ready_in) begin
          ir_set  = 1'b1;
          state_d = S_ID;
        end
      end
      S_ID: begin
        if (run) begin
          opcode_en = 1'b1;
          state_d   = S_EX;
        end
      end
      S_EX: begin
        if (run) begin
          if (is_load || is_store) begin
            state_d = S_MEM;
          end else if (is_branch) begin
            pc_set  = 1'b1;
            pc_sel  = bus.multicycle_control_branch_taken_in ? SEL_BR : SEL_PC4;
            state_d = S_IF;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (run && bus.multicycle_control_dmem_ready_in) begin
          if (is_store) begin
            pc_set  = 1'b1;
            state_d = S_IF;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        if (run) begin
          pc_set  = 1'b1;
          rf_we   = writes_rf;
          state_d = S_IF;
          if (opcode_q == OP_JAL) begin
            pc_sel = SEL_JAL;
          end else if (opcode_q == OP_JALR) begin
            pc_sel = SEL_JALR;
          end
        end
      end
`ifdef MULTICYCLE_CONTROL_TIMEOUT_EN
      S_FAULT: begin
        fault = 1'b1;
      end
`endif
      default: begin
        state_d = S_IF;
      end
    endcase

`ifdef MULTICYCLE_CONTROL_TIMEOUT_EN
    if (tmo_hit) begin
      state_d = S_FAULT;
    end
`else
    if (tmo_hit) begin
      state_d = S_IF;
    end
`endif
  end

  assign bus.multicycle_control_imem_req_out   = imem_req;
  assign bus.multicycle_control_dmem_req_out   = dmem_req;
  assign bus.multicycle_control_dmem_we_out    = dmem_we;
  assign bus.multicycle_control_pc_set_val_out = pc_set;
  assign bus.multicycle_control_ir_set_val_out = ir_set;
  assign bus.multicycle_control_pc_mux_sel_out = pc_sel;
  assign bus.multicycle_control_rf_we_out      = rf_we;
  assign bus.multicycle_control_state_out      = state_q;
  assign bus.multicycle_control_fault_out      = fault;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected output vectors
// are queued as stimulus is driven and compared on the falling edge.
module tb_multicycle_control;
  localparam int PC_SEL_W    = 2;
  localparam int OPCODE_W    = 7;
  localparam int MEM_TIMEOUT = 15;

  localparam logic [2:0] ST_IF  = 3'b000;
  localparam logic [2:0] ST_ID  = 3'b001;
  localparam logic [2:0] ST_EX  = 3'b011;
  localparam logic [2:0] ST_MEM = 3'b010;
  localparam logic [2:0] ST_WB  = 3'b110;
  localparam logic [2:0] ST_FLT = 3'b111;

  // Opcode driven outside ID; if the FSM used the live IR it would see JAL.
  localparam logic [6:0] G = 7'b1101111;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_control_if #(.PC_SEL_W(PC_SEL_W), .OPCODE_W(OPCODE_W)) bus ();

  multicycle_control #(
    .PC_SEL_W(PC_SEL_W), .OPCODE_W(OPCODE_W), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .multicycle_control_clock_in(clk),
    .multicycle_control_reset_in(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       imr, dmr, we, pcs, irs;
    logic [1:0] sel;
    logic       rfw, flt;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic exp_t e(logic [2:0] st, logic imr, logic dmr, logic we,
                             logic pcs, logic irs, logic [1:0] sel, logic rfw, logic flt);
    exp_t r;
    r = '{st: st, imr: imr, dmr: dmr, we: we, pcs: pcs, irs: irs, sel: sel, rfw: rfw, flt: flt};
    return r;
  endfunction

  // Drive one cycle (called at posedge+1), compare at negedge, return at posedge+1.
  task automatic step(input string tag, input logic stl, input logic im, input logic dm,
                      input logic bt, input logic [6:0] op, input exp_t ex);
    exp_t got, want;
    bus.multicycle_control_stall_in        = stl;
    bus.multicycle_control_imem_ready_in   = im;
    bus.multicycle_control_dmem_ready_in   = dm;
    bus.multicycle_control_branch_taken_in = bt;
    bus.multicycle_control_opcode_in       = op;
    sb.push_back(ex);
    @(negedge clk);
    got = '{st: bus.multicycle_control_state_out,
            imr: bus.multicycle_control_imem_req_out,
            dmr: bus.multicycle_control_dmem_req_out,
            we: bus.multicycle_control_dmem_we_out,
            pcs: bus.multicycle_control_pc_set_val_out,
            irs: bus.multicycle_control_ir_set_val_out,
            sel: bus.multicycle_control_pc_mux_sel_out,
            rfw: bus.multicycle_control_rf_we_out,
            flt: bus.multicycle_control_fault_out};
    want = sb.pop_front();
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (st imr dmr we pcs irs sel rfw flt)",
             tag, got, want);
    end
    @(posedge clk);
    #1;
  endtask

  // IF with ready (IR load pulse) followed by ID with the opcode on the bus.
  task automatic fetch(input string tag, input logic [6:0] op);
    step({tag, "_if"}, 1'b0, 1'b1, 1'b1, 1'b0, G,  e(ST_IF, 1, 0, 0, 0, 1, 2'd0, 0, 0));
    step({tag, "_id"}, 1'b0, 1'b1, 1'b1, 1'b0, op, e(ST_ID, 0, 0, 0, 0, 0, 2'd0, 0, 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.multicycle_control_stall_in        = 1'b0;
    bus.multicycle_control_imem_ready_in   = 1'b1;
    bus.multicycle_control_dmem_ready_in   = 1'b1;
    bus.multicycle_control_branch_taken_in = 1'b0;
    bus.multicycle_control_opcode_in       = G;
    @(posedge clk);
    #1;
    // Reset: IF, imem_req only, no IR pulse despite ready.
    step("rst0", 0, 1, 1, 0, G, e(ST_IF, 1, 0, 0, 0, 0, 2'd0, 0, 0));
    step("rst1", 0, 1, 1, 0, G, e(ST_IF, 1, 0, 0, 0, 0, 2'd0, 0, 0));
    rst_n = 1'b1;

    // ADDI: IF, ID, EX, WB (rf_we, pc+4).
    fetch("addi", 7'b0010011);
    step("addi_ex", 0, 1, 1, 0, G, e(ST_EX, 0, 0, 0, 0, 0, 2'd0, 0, 0));
    step("addi_wb", 0, 1, 1, 0, G, e(ST_WB, 0, 0, 0, 1, 0, 2'd0, 1, 0));

    // BEQ taken and not taken: resolved in EX, no WB.
    fetch("beq_t", 7'b1100011);
    step("beq_t_ex", 0, 1, 1, 1, G, e(ST_EX, 0, 0, 0, 1, 0, 2'd1, 0, 0));
    fetch("beq_n", 7'b1100011);
    step("beq_n_ex", 0, 1, 1, 0, G, e(ST_EX, 0, 0, 0, 1, 0, 2'd0, 0, 0));

    // LW with two imem wait cycles, then dmem_ready low for 3 cycles.
    step("lw_iw0", 0, 0, 1, 0, G, e(ST_IF, 1, 0, 0, 0, 0, 2'd0, 0, 0));
    step("lw_iw1", 0, 0, 1, 0, G, e(ST_IF, 1, 0, 0, 0, 0, 2'd0, 0, 0));
    fetch("lw", 7'b0000011);
    step("lw_ex",   0, 1, 1, 0, G, e(ST_EX,  0, 0, 0, 0, 0, 2'd0, 0, 0));
    step("lw_mw0",  0, 1, 0, 0, G, e(ST_MEM, 0, 1, 0, 0, 0, 2'd0, 0, 0));
    step("lw_mw1",  0, 1, 0, 0, G, e(ST_MEM, 0, 1, 0, 0, 0, 2'd0, 0, 0));
    step("lw_mw2",  0, 1, 0, 0, G, e(ST_MEM, 0, 1, 0, 0, 0, 2'd0, 0, 0));
    step("lw_mrdy", 0, 1, 1, 0, G, e(ST_MEM, 0, 1, 0, 0, 0, 2'd0, 0, 0));
    step("lw_wb",   0, 1, 1, 0, G, e(ST_WB,  0, 0, 0, 1, 0, 2'd0, 1, 0));

    // SW stalled 2 cycles in MEM with ready high; stall wins over ready.
    fetch("sw", 7'b0100011);
    step("sw_ex",  0, 1, 1, 0, G, e(ST_EX,  0, 0, 0, 0, 0, 2'd0, 0, 0));
    step("sw_st0", 1, 1, 1, 0, G, e(ST_MEM, 0, 1, 1, 0, 0, 2'd0, 0, 0));
    step("sw_st1", 1, 1, 1, 0, G, e(ST_MEM, 0, 1, 1, 0, 0, 2'd0, 0, 0));
    step("sw_mem", 0, 1, 1, 0, G, e(ST_MEM, 0, 1, 1, 1, 0, 2'd0, 0, 0));

    // Stall in IF with ready, then JALR with a stalled WB cycle.
    step("if_stall", 1, 1, 1, 0, G, e(ST_IF, 1, 0, 0, 0, 0, 2'd0, 0, 0));
    fetch("jalr", 7'b1100111);
    step("jalr_ex",  0, 1, 1, 0, G, e(ST_EX, 0, 0, 0, 0, 0, 2'd0, 0, 0));
    step("jalr_wbs", 1, 1, 1, 0, G, e(ST_WB, 0, 0, 0, 0, 0, 2'd0, 0, 0));
    step("jalr_wb",  0, 1, 1, 0, G, e(ST_WB, 0, 0, 0, 1, 0, 2'd3, 1, 0));

    // JAL, LUI, and an illegal opcode retiring as a NOP.
    fetch("jal", 7'b1101111);
    step("jal_ex", 0, 1, 1, 0, 7'b0000000, e(ST_EX, 0, 0, 0, 0, 0, 2'd0, 0, 0));
    step("jal_wb", 0, 1, 1, 0, 7'b0000000, e(ST_WB, 0, 0, 0, 1, 0, 2'd2, 1, 0));
    fetch("lui", 7'b0110111);
    step("lui_ex", 0, 1, 1, 0, G, e(ST_EX, 0, 0, 0, 0, 0, 2'd0, 0, 0));
    step("lui_wb", 0, 1, 1, 0, G, e(ST_WB, 0, 0, 0, 1, 0, 2'd0, 1, 0));
    fetch("ill", 7'b1111111);
    step("ill_ex", 0, 1, 1, 0, G, e(ST_EX, 0, 0, 0, 0, 0, 2'd0, 0, 0));
    step("ill_wb", 0, 1, 1, 0, G, e(ST_WB, 0, 0, 0, 1, 0, 2'd0, 0, 0));

    // Async reset while in EX: back to IF at once, no strobes.
    fetch("mrst", 7'b0010011);
    rst_n = 1'b0;
    step("mrst_0", 0, 1, 1, 0, G, e(ST_IF, 1, 0, 0, 0, 0, 2'd0, 0, 0));
    step("mrst_1", 0, 1, 1, 0, G, e(ST_IF, 1, 0, 0, 0, 0, 2'd0, 0, 0));
    rst_n = 1'b1;
    fetch("post", 7'b0010011);
    step("post_ex", 0, 1, 1, 0, G, e(ST_EX, 0, 0, 0, 0, 0, 2'd0, 0, 0));
    step("post_wb", 0, 1, 1, 0, G, e(ST_WB, 0, 0, 0, 1, 0, 2'd0, 1, 0));

`ifdef MULTICYCLE_CONTROL_TIMEOUT_EN
    // imem_ready held low: MEM_TIMEOUT cycles in IF, then sticky FAULT.
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      step("tmo_wait", 0, 0, 1, 0, G, e(ST_IF, 1, 0, 0, 0, 0, 2'd0, 0, 0));
    end
    for (int i = 0; i < 3; i++) begin
      step("tmo_fault", 0, (i != 0), 1, 0, G, e(ST_FLT, 0, 0, 0, 0, 0, 2'd0, 0, 1));
    end
    rst_n = 1'b0;
    step("tmo_rst", 0, 1, 1, 0, G, e(ST_IF, 1, 0, 0, 0, 0, 2'd0, 0, 0));
    rst_n = 1'b1;
    fetch("tmo_post", 7'b0010011);
`else
    // No timeout: IF waits indefinitely, fault stays 0.
    for (int i = 0; i < 100; i++) begin
      step("nofault_wait", 0, 0, 1, 0, G, e(ST_IF, 1, 0, 0, 0, 0, 2'd0, 0, 0));
    end
    fetch("nofault_post", 7'b0010011);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
